// File: rtl/piso_stream.sv
// piso_stream: parallel-in serial-out serialiser with a one-word hold
// buffer and valid/ready handshakes on both sides.
module piso_stream #(
   parameter int    DATA_WIDTH   = 8,
   parameter int    LANES        = 1,
   parameter string DO_MSB_FIRST = "true"
) (
   input  logic                  i_clk,
   input  logic                  i_s_rst_n,
   input  logic                  i_wr_en,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_rd_en,
   output logic                  o_data_valid,
   output logic [LANES-1:0]      o_data,
   output logic                  o_first,
   output logic                  o_last
);

   localparam int BEATS = DATA_WIDTH / LANES;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
   localparam bit MSB_FIRST = (DO_MSB_FIRST == "true");

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  hold_full_q, hold_full_d;

   logic                  valid;
   logic                  last;
   logic                  accept;
   logic                  consume;
   logic                  done;
   logic [LANES-1:0]      beat;
   logic [DATA_WIDTH-1:0] shifted;

   // The current beat always sits at the emitting end of the shifter.
   if (MSB_FIRST) begin : g_msb
      assign beat    = shift_q[DATA_WIDTH-1 -: LANES];
      assign shifted = shift_q << LANES;
   end else begin : g_lsb
      assign beat    = shift_q[LANES-1:0];
      assign shifted = shift_q >> LANES;
   end

   assign valid   = (state_q == SHIFT);
   assign last    = (cnt_q == LAST_CNT);
   assign o_ready = !hold_full_q && i_s_rst_n;
   assign accept  = i_wr_en && o_ready;
   assign consume = valid && i_rd_en;
   assign done    = consume && last;

   assign o_data_valid = valid;
   assign o_data       = valid ? beat : '0;
   assign o_first      = valid && (cnt_q == '0);
   assign o_last       = valid && last;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = i_data;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (done) begin
               cnt_d = '0;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  shift_d = i_data;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (consume) begin
                  shift_d = shifted;
                  cnt_d   = cnt_q + CW'(1);
               end
               if (accept) begin
                  hold_d      = i_data;
                  hold_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_s_rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: two serialiser configurations (8x1 MSB-first and
// 8x2 LSB-first) driven in parallel against a word-queue model.
module tb_piso_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr;
   logic       rd;
   logic [7:0] din;

   logic       rdy0, v0, d0, f0, l0;
   logic       rdy1, v1, f1, l1;
   logic [1:0] d1;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   piso_stream #(
      .DATA_WIDTH  (8),
      .LANES       (1),
      .DO_MSB_FIRST("true")
   ) u0 (
      .i_clk       (clk),
      .i_s_rst_n   (rst_n),
      .i_wr_en     (wr),
      .o_ready     (rdy0),
      .i_data      (din),
      .i_rd_en     (rd),
      .o_data_valid(v0),
      .o_data      (d0),
      .o_first     (f0),
      .o_last      (l0)
   );

   piso_stream #(
      .DATA_WIDTH  (8),
      .LANES       (2),
      .DO_MSB_FIRST("false")
   ) u1 (
      .i_clk       (clk),
      .i_s_rst_n   (rst_n),
      .i_wr_en     (wr),
      .o_ready     (rdy1),
      .i_data      (din),
      .i_rd_en     (rd),
      .o_data_valid(v1),
      .o_data      (d1),
      .o_first     (f1),
      .o_last      (l1)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic [7:0] d,
                       input logic r);
      wr  = w;
      din = d;
      rd  = r;
      @(posedge clk);
      #1;
   endtask

   // Model: words in flight in arrival order, plus beat index of the head.
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         i0 = 0;
   int         i1 = 0;

   initial begin
      logic       a0, a1;
      logic       ev0, ef0, el0, er0, eb0;
      logic       ev1, ef1, el1, er1;
      logic [1:0] eb1;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            q0.delete();
            q1.delete();
            i0 = 0;
            i1 = 0;
         end else begin
            a0 = wr && (q0.size() < 2);
            a1 = wr && (q1.size() < 2);
            if (q0.size() > 0 && rd) begin
               i0++;
               if (i0 == 8) begin
                  void'(q0.pop_front());
                  i0 = 0;
               end
            end
            if (q1.size() > 0 && rd) begin
               i1++;
               if (i1 == 4) begin
                  void'(q1.pop_front());
                  i1 = 0;
               end
            end
            if (a0) q0.push_back(din);
            if (a1) q1.push_back(din);
         end
         @(negedge clk);
         if (mon_en) begin
            ev0 = q0.size() > 0;
            ev1 = q1.size() > 0;
            eb0 = 1'b0;
            eb1 = 2'b00;
            if (ev0) eb0 = q0[0][7-i0];
            if (ev1) eb1 = 2'((q1[0] >> (2 * i1)) & 8'h03);
            ef0 = ev0 && (i0 == 0);
            el0 = ev0 && (i0 == 7);
            ef1 = ev1 && (i1 == 0);
            el1 = ev1 && (i1 == 3);
            er0 = rst_n && (q0.size() < 2);
            er1 = rst_n && (q1.size() < 2);
            chk("mon_u0", {27'b0, rdy0, v0, d0, f0, l0},
                {27'b0, er0, ev0, eb0, ef0, el0});
            chk("mon_u1", {26'b0, rdy1, v1, d1, f1, l1},
                {26'b0, er1, ev1, eb1, ef1, el1});
         end
      end
   end

   typedef struct {
      logic       w;
      logic [7:0] d;
      logic [3:0] e0;
      logic [4:0] e1;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [7:0] d,
                               input logic [3:0] e0,
                               input logic [4:0] e1);
      vec_t v;
      v.w  = w;
      v.d  = d;
      v.e0 = e0;
      v.e1 = e1;
      return v;
   endfunction

   vec_t       tbl[18];
   logic [7:0] words[3];
   logic [23:0] col;
   int         k, nv, nc, rlow, fst, lst;
   logic       took;

   initial begin
      // e0 = {valid, data, first, last}; e1 = {valid, data[1:0], first, last}
      tbl[0]  = mk(1'b1, 8'hA5, 4'b1110, 5'b10110);
      tbl[1]  = mk(1'b0, 8'h00, 4'b1000, 5'b10100);
      tbl[2]  = mk(1'b0, 8'h00, 4'b1100, 5'b11000);
      tbl[3]  = mk(1'b0, 8'h00, 4'b1000, 5'b11001);
      tbl[4]  = mk(1'b0, 8'h00, 4'b1000, 5'b00000);
      tbl[5]  = mk(1'b0, 8'h00, 4'b1100, 5'b00000);
      tbl[6]  = mk(1'b0, 8'h00, 4'b1000, 5'b00000);
      tbl[7]  = mk(1'b0, 8'h00, 4'b1101, 5'b00000);
      tbl[8]  = mk(1'b0, 8'h00, 4'b0000, 5'b00000);
      tbl[9]  = mk(1'b1, 8'hB4, 4'b1110, 5'b10010);
      tbl[10] = mk(1'b0, 8'h00, 4'b1000, 5'b10100);
      tbl[11] = mk(1'b0, 8'h00, 4'b1100, 5'b11100);
      tbl[12] = mk(1'b0, 8'h00, 4'b1100, 5'b11001);
      tbl[13] = mk(1'b0, 8'h00, 4'b1000, 5'b00000);
      tbl[14] = mk(1'b0, 8'h00, 4'b1100, 5'b00000);
      tbl[15] = mk(1'b0, 8'h00, 4'b1000, 5'b00000);
      tbl[16] = mk(1'b0, 8'h00, 4'b1001, 5'b00000);
      tbl[17] = mk(1'b0, 8'h00, 4'b0000, 5'b00000);

      rst_n = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h77, 1'b1);
      chk("rst_u0", {27'b0, rdy0, v0, d0, f0, l0}, 32'd0);
      chk("rst_u1", {26'b0, rdy1, v1, d1, f1, l1}, 32'd0);
      wr = 1'b0;
      rst_n = 1'b1;
      mon_en = 1'b1;
      #1;
      chk("rdy_rel_u0", {31'b0, rdy0}, 32'd1);
      chk("rdy_rel_u1", {31'b0, rdy1}, 32'd1);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].w, tbl[i].d, 1'b1);
         chk($sformatf("tbl%0d_u0", i),
             {27'b0, rdy0, v0, d0, f0, l0}, {27'b0, 1'b1, tbl[i].e0});
         chk($sformatf("tbl%0d_u1", i),
             {26'b0, rdy1, v1, d1, f1, l1}, {26'b0, 1'b1, tbl[i].e1});
      end

      // Back-to-back words with the producer always offering the next one.
      words = '{8'h0F, 8'hF0, 8'h3C};
      k = 0; nv = 0; rlow = 0; fst = -1; lst = 0; col = '0;
      wr = 1'b1; din = words[0]; rd = 1'b1;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         took = wr && rdy0;
         if (!rdy0) rlow++;
         if (v0) begin
            nv++;
            if (fst < 0) fst = t;
            lst = t;
            col = {col[22:0], d0};
         end
         @(posedge clk);
         #1;
         if (took) begin
            k++;
            if (k == 3) wr = 1'b0;
            else din = words[k];
         end
      end
      chk("b2b_beats", nv, 32'd24);
      chk("b2b_gapless", lst - fst + 1, 32'd24);
      chk("b2b_data", {8'b0, col}, 32'h000FF03C);
      chk("b2b_rdy_low", rlow, 32'd14);

      // Backpressure on beat 3 for three cycles.
      nv = 0; nc = 0; col = '0;
      for (int t = 0; t < 16; t++) begin
         wr  = (t == 0);
         din = 8'hC3;
         rd  = !(t >= 4 && t <= 6);
         @(negedge clk);
         if (v0) nv++;
         if (v0 && rd) begin
            nc++;
            col = {col[22:0], d0};
         end
         @(posedge clk);
         #1;
      end
      chk("bp_valid_cycles", nv, 32'd11);
      chk("bp_beats", nc, 32'd8);
      chk("bp_data", {24'b0, col[7:0]}, 32'h000000C3);

      // Third write arrives while the hold buffer is full.
      words = '{8'h11, 8'h22, 8'h55};
      nc = 0; col = '0;
      for (int t = 0; t < 25; t++) begin
         wr  = (t < 3);
         din = words[t % 3];
         rd  = 1'b1;
         @(negedge clk);
         if (t == 2) chk("full_rdy", {31'b0, rdy0}, 32'd0);
         if (v0) begin
            nc++;
            col = {col[22:0], d0};
         end
         @(posedge clk);
         #1;
      end
      chk("full_beats", nc, 32'd16);
      chk("full_data", {16'b0, col[15:0]}, 32'h00001122);

      // Reset while beat 2 is showing and the hold buffer is full.
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("mid_pre_u0", {27'b0, rdy0, v0, d0, f0, l0}, 32'h0000000C);
      rst_n = 1'b0;
      step(1'b0, 8'h00, 1'b1);
      chk("mid_rst_u0", {27'b0, rdy0, v0, d0, f0, l0}, 32'd0);
      chk("mid_rst_u1", {26'b0, rdy1, v1, d1, f1, l1}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_u0", {30'b0, rdy0, v0}, 32'd2);
      nc = 0; col = '0;
      for (int t = 0; t < 14; t++) begin
         wr  = (t == 0);
         din = 8'h81;
         rd  = 1'b1;
         @(negedge clk);
         if (v0) begin
            nc++;
            col = {col[22:0], d0};
         end
         @(posedge clk);
         #1;
      end
      chk("mid_beats", nc, 32'd8);
      chk("mid_data", {24'b0, col[7:0]}, 32'h00000081);

      for (int t = 0; t < 800; t++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         step(1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 9) < 7));
      end
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
